// File: rtl/adder_ahead_pipe_if.sv
// Operand/result bus for the pipelined lookahead adder.
// Carries the valid/ready handshake on both sides plus the result flags.
interface adder_ahead_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;
  logic             g_o;
  logic             p_o;

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, g_o, p_o
  );

  modport master (
    output in_valid_i, a_i, b_i, cin_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, g_o, p_o
  );
endinterface

// File: rtl/adder_ahead_pipe.sv
// Two-stage pipelined carry-lookahead adder built from 4-bit lookahead groups.
// Stage 1 captures operands and per-group G/P; stage 2 resolves group carries,
// ripples inside each group, and registers sum, carry-out, overflow and the
// block-level G/P used when chaining instances under an external lookahead.
module adder_ahead_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  adder_ahead_pipe_if.slave    bus
);

  localparam int NG = WIDTH / 4;

  // 4-bit lookahead group: returns {G, P} from bit-level generate/propagate.
  function automatic logic [1:0] grp_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  // ---- stage 0: bit-level g/p and group G/P from the raw operands ----
  logic [WIDTH-1:0] g_bit_p0;
  logic [WIDTH-1:0] p_bit_p0;
  logic [NG-1:0]    gg_p0;
  logic [NG-1:0]    pg_p0;

  assign g_bit_p0 = bus.a_i & bus.b_i;
  assign p_bit_p0 = bus.a_i | bus.b_i;

  // Fold each nibble of bit-level g/p into its group generate/propagate.
  always_comb begin
    gg_p0 = '0;
    pg_p0 = '0;
    for (int k = 0; k < NG; k++) begin
      {gg_p0[k], pg_p0[k]} = grp_gp(g_bit_p0[4*k +: 4], p_bit_p0[4*k +: 4]);
    end
  end

  // ---- handshake: both stages advance together when the output drains ----
  logic vld_p1;
  logic vld_p2;
  logic s1_en;
  logic s2_en;

  assign s2_en          = !vld_p2 | bus.out_ready_i;
  assign s1_en          = !vld_p1 | s2_en;
  assign bus.in_ready_o = s1_en;

  // ---- stage 1 registers ----
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             cin_p1;
  logic [NG-1:0]    gg_p1;
  logic [NG-1:0]    pg_p1;

  // Stage 1 capture: load operands and group G/P whenever stage 1 may advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      cin_p1 <= 1'b0;
      gg_p1  <= '0;
      pg_p1  <= '0;
    end else if (s1_en) begin
      vld_p1 <= bus.in_valid_i;
      a_p1   <= bus.a_i;
      b_p1   <= bus.b_i;
      cin_p1 <= bus.cin_i;
      gg_p1  <= gg_p0;
      pg_p1  <= pg_p0;
    end
  end

  // ---- stage 1 -> 2 combinational: group carries, in-group ripple, flags ----
  logic [WIDTH-1:0] g_bit_p1;
  logic [WIDTH-1:0] p_bit_p1;
  logic [NG-1:0]    cgrp_p1;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             cmsb_c;
  logic             blk_g_c;
  logic             c_run;

  assign g_bit_p1 = a_p1 & b_p1;
  assign p_bit_p1 = a_p1 | b_p1;

  // Resolve carries: lookahead across groups, then ripple within each group.
  always_comb begin
    cgrp_p1 = '0;
    sum_c   = '0;
    cmsb_c  = 1'b0;
    blk_g_c = 1'b0;
    c_run   = cin_p1;
    for (int k = 0; k < NG; k++) begin
      cgrp_p1[k] = c_run;
      c_run      = gg_p1[k] | (pg_p1[k] & c_run);
    end
    cout_c = c_run;
    for (int k = 0; k < NG; k++) begin
      c_run = cgrp_p1[k];
      for (int j = 0; j < 4; j++) begin
        sum_c[4*k+j] = a_p1[4*k+j] ^ b_p1[4*k+j] ^ c_run;
        if (4*k + j == WIDTH - 1) begin
          cmsb_c = c_run;
        end
        c_run = g_bit_p1[4*k+j] | (p_bit_p1[4*k+j] & c_run);
      end
    end
    // Block generate is the group-carry chain evaluated with carry-in forced to 0.
    for (int k = 0; k < NG; k++) begin
      blk_g_c = gg_p1[k] | (pg_p1[k] & blk_g_c);
    end
  end

  // ---- stage 2 registers ----
  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2;
  logic             ovf_p2;
  logic             g_p2;
  logic             p_p2;

  // Stage 2 capture: register the resolved result whenever the output can move.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      g_p2    <= 1'b0;
      p_p2    <= 1'b0;
    end else if (s2_en) begin
      vld_p2  <= vld_p1;
      sum_p2  <= sum_c;
      cout_p2 <= cout_c;
      ovf_p2  <= cmsb_c ^ cout_c;
      g_p2    <= blk_g_c;
      p_p2    <= &pg_p1;
    end
  end

  assign bus.out_valid_o = vld_p2;
  assign bus.sum_o       = sum_p2;
  assign bus.cout_o      = cout_p2;
  assign bus.ovf_o       = ovf_p2;
  assign bus.g_o         = g_p2;
  assign bus.p_o         = p_p2;

endmodule
